// File: rtl/cv32e40p_pkg.sv
// Shared types for the CV32E40P fetch path: aligner state encoding.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    ALIGNED           = 2'd0,
    MISALIGNED        = 2'd1,
    BRANCH_MISALIGNED = 2'd2
  } aligner_state_e;

  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/cv32e40p_fetch_aligner.sv
// Realigns word-aligned fetch data into 16/32-bit instructions for the compressed decoder.
// Optional hardware-loop redirect enabled by defining CV32E40P_ALIGNER_HWLP_EN.
//
// state             | meaning
// ALIGNED           | next instruction starts at bit 0 of the fetch word
// MISALIGNED        | next instruction starts in the held half r_h
// BRANCH_MISALIGNED | redirect to pc[1]=1; drop the low half of the next word
module cv32e40p_fetch_aligner
  import cv32e40p_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_aligned_o,
  output logic [31:0] pc_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        hwlp_jump_i,
  input  logic [31:0] hwlp_target_i
);

  aligner_state_e r_state, w_state_n;
  logic [31:0]    r_pc, w_pc_n;
  logic [15:0]    r_h, w_h_n;
  logic           r_boot, w_boot_n;
  logic           w_hs;
  logic           w_unused;

`ifdef CV32E40P_ALIGNER_HWLP_EN
  assign w_unused = ^{branch_addr_i[0], hwlp_target_i[0]};
`else
  assign w_unused = ^{branch_addr_i[0], hwlp_jump_i, hwlp_target_i};
`endif

  assign pc_o = r_pc;
  assign w_hs = instr_valid_o && instr_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ALIGNED;
      r_pc    <= 32'd0;
      r_h     <= 16'd0;
      r_boot  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_h     <= w_h_n;
      r_boot  <= w_boot_n;
    end
  end

  always_comb begin
    w_state_n       = r_state;
    w_pc_n          = r_pc;
    w_h_n           = r_h;
    w_boot_n        = r_boot;
    instr_valid_o   = 1'b0;
    fetch_ready_o   = 1'b0;
    instr_aligned_o = fetch_rdata_i;

    // Nothing is issued out of reset until the boot redirect arrives.
    if (r_boot) begin
      unique case (r_state)
        ALIGNED: begin
          instr_valid_o = fetch_valid_i;
          if (is_compressed(fetch_rdata_i[15:0])) begin
            instr_aligned_o = {16'h0000, fetch_rdata_i[15:0]};
            if (w_hs) begin
              fetch_ready_o = 1'b1;
              w_h_n         = fetch_rdata_i[31:16];
              w_pc_n        = r_pc + 32'd2;
              w_state_n     = MISALIGNED;
            end
          end else if (w_hs) begin
            fetch_ready_o = 1'b1;
            w_pc_n        = r_pc + 32'd4;
          end
        end
        MISALIGNED: begin
          if (is_compressed(r_h)) begin
            instr_valid_o   = 1'b1;
            instr_aligned_o = {16'h0000, r_h};
            if (w_hs) begin
              w_pc_n    = r_pc + 32'd2;
              w_state_n = ALIGNED;
            end
          end else begin
            instr_valid_o   = fetch_valid_i;
            instr_aligned_o = {fetch_rdata_i[15:0], r_h};
            if (w_hs) begin
              fetch_ready_o = 1'b1;
              w_h_n         = fetch_rdata_i[31:16];
              w_pc_n        = r_pc + 32'd4;
            end
          end
        end
        BRANCH_MISALIGNED: begin
          if (fetch_valid_i) begin
            fetch_ready_o = 1'b1;
            w_h_n         = fetch_rdata_i[31:16];
            w_state_n     = MISALIGNED;
          end
        end
        default: w_state_n = ALIGNED;
      endcase
    end

`ifdef CV32E40P_ALIGNER_HWLP_EN
    // Loop jump keeps the fetch consumption decided above, only the target changes.
    if (w_hs && hwlp_jump_i) begin
      w_pc_n    = {hwlp_target_i[31:1], 1'b0};
      w_state_n = hwlp_target_i[1] ? BRANCH_MISALIGNED : ALIGNED;
    end
`endif

    if (branch_i) begin
      instr_valid_o = 1'b0;
      fetch_ready_o = 1'b0;
      w_h_n         = r_h;
      w_pc_n        = {branch_addr_i[31:1], 1'b0};
      w_state_n     = branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED;
      w_boot_n      = 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40p_fetch_aligner.sv
// Directed self-checking bench for cv32e40p_fetch_aligner (either CV32E40P_ALIGNER_HWLP_EN setting).
module tb_cv32e40p_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_aligned_o;
  logic [31:0] pc_o;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        hwlp_jump_i;
  logic [31:0] hwlp_target_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40p_fetch_aligner dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_rdata_i   (fetch_rdata_i),
    .fetch_ready_o   (fetch_ready_o),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_aligned_o (instr_aligned_o),
    .pc_o            (pc_o),
    .branch_i        (branch_i),
    .branch_addr_i   (branch_addr_i),
    .hwlp_jump_i     (hwlp_jump_i),
    .hwlp_target_i   (hwlp_target_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic [31:0] ba, input logic fv,
                       input logic [31:0] fd, input logic rdy);
    branch_i      = br;
    branch_addr_i = ba;
    fetch_valid_i = fv;
    fetch_rdata_i = fd;
    instr_ready_i = rdy;
    #2;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic r,
                         input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, instr_valid_o}, {31'd0, v});
    chk({tag, ".fready"}, {31'd0, fetch_ready_o}, {31'd0, r});
    if (v) chk({tag, ".instr"}, instr_aligned_o, ins);
    chk({tag, ".pc"}, pc_o, pc);
  endtask

  logic [31:0] hwlp_exp;

  initial begin
    rst_n = 1'b0;
    hwlp_jump_i = 1'b0;
    hwlp_target_i = 32'd0;
    drive(1'b0, 32'd0, 1'b1, 32'h0041_0113, 1'b1);
    chk_out("reset", 1'b0, 1'b0, 32'd0, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk_out("unbooted", 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    chk_out("unbooted2", 1'b0, 1'b0, 32'd0, 32'd0);

    // 32-bit instruction at aligned pc
    drive(1'b1, 32'h100, 1'b1, 32'h0041_0113, 1'b1);
    chk_out("br100", 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    drive(1'b0, 32'd0, 1'b1, 32'h0041_0113, 1'b1);
    chk_out("addi", 1'b1, 1'b1, 32'h0041_0113, 32'h100);
    cyc();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk_out("addi.next", 1'b0, 1'b0, 32'd0, 32'h104);

    // Two compressed instructions in one word
    drive(1'b1, 32'h200, 1'b0, 32'd0, 1'b1);
    cyc();
    drive(1'b0, 32'd0, 1'b1, 32'h4501_4505, 1'b1);
    chk_out("cli0", 1'b1, 1'b1, 32'h0000_4505, 32'h200);
    cyc();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk_out("cli1", 1'b1, 1'b0, 32'h0000_4501, 32'h202);
    cyc();
    chk_out("cli.after", 1'b0, 1'b0, 32'd0, 32'h204);

    // 32-bit instruction straddling two words
    drive(1'b1, 32'h300, 1'b0, 32'd0, 1'b1);
    cyc();
    drive(1'b0, 32'd0, 1'b1, 32'h0113_4505, 1'b1);
    chk_out("str.c", 1'b1, 1'b1, 32'h0000_4505, 32'h300);
    cyc();
    drive(1'b0, 32'd0, 1'b1, 32'hABCD_0041, 1'b1);
    chk_out("str.w", 1'b1, 1'b1, 32'h0041_0113, 32'h302);
    cyc();
    // Stall on the held compressed half 0xABCD
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk_out("held", 1'b1, 1'b0, 32'h0000_ABCD, 32'h306);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("stall", 1'b1, 1'b0, 32'h0000_ABCD, 32'h306);
    end

    // Branch mid-stall to a misaligned target
    drive(1'b1, 32'h402, 1'b1, 32'h1234_5678, 1'b0);
    chk_out("br402", 1'b0, 1'b0, 32'd0, 32'h306);
    cyc();
    drive(1'b0, 32'd0, 1'b1, 32'h4505_FFFF, 1'b1);
    chk_out("bubble", 1'b0, 1'b1, 32'd0, 32'h402);
    cyc();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk_out("bm.c", 1'b1, 1'b0, 32'h0000_4505, 32'h402);
    cyc();
    chk_out("bm.after", 1'b0, 1'b0, 32'd0, 32'h404);

    // Bit 0 of the target ignored; pc wraps past 2^32
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1);
    cyc();
    drive(1'b0, 32'd0, 1'b1, 32'h0001_FFFF, 1'b1);
    chk_out("wrap.bubble", 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFE);
    cyc();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk_out("wrap.c", 1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    cyc();
    chk_out("wrap.pc", 1'b0, 1'b0, 32'd0, 32'h0);

    // Asynchronous reset while holding r_h = 0x0041
    drive(1'b1, 32'h500, 1'b0, 32'd0, 1'b1);
    cyc();
    drive(1'b0, 32'd0, 1'b1, 32'h0041_4505, 1'b1);
    cyc();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk_out("pre.rst", 1'b1, 1'b0, 32'h0000_0041, 32'h502);
    rst_n = 1'b0;
    #1;
    chk_out("async.rst", 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 32'h0041_0113, 1'b1);
    chk_out("rst.unbooted", 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    chk_out("rst.unbooted2", 1'b0, 1'b0, 32'd0, 32'd0);

    // Hardware-loop jump on a 32-bit instruction
    drive(1'b1, 32'h600, 1'b0, 32'd0, 1'b1);
    cyc();
    hwlp_jump_i   = 1'b1;
    hwlp_target_i = 32'h500;
    drive(1'b0, 32'd0, 1'b1, 32'h0041_0113, 1'b1);
    chk_out("hwlp", 1'b1, 1'b1, 32'h0041_0113, 32'h600);
    cyc();
    hwlp_jump_i = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
`ifdef CV32E40P_ALIGNER_HWLP_EN
    hwlp_exp = 32'h500;
`else
    hwlp_exp = 32'h604;
`endif
    chk_out("hwlp.pc", 1'b0, 1'b0, 32'd0, hwlp_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40p_fetch_aligner.md
CV32E40P_FETCH_ALIGNER -- requirements
Module: cv32e40p_fetch_aligner

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 fetch_valid_i  input  1  prefetch buffer word valid.
REQ-005 fetch_rdata_i  input  32  word-aligned fetch word.
REQ-006 fetch_ready_o  output  1  word consumed this cycle (with fetch_valid_i).
REQ-007 instr_valid_o  output  1  aligned instruction valid toward compressed decoder.
REQ-008 instr_ready_i  input  1  ID stage accepts instruction.
REQ-009 instr_aligned_o  output  32  aligned instruction; compressed encodings zero-extended in [31:16].
REQ-010 pc_o  output  32  byte address of instr_aligned_o.
REQ-011 branch_i  input  1  redirect request.
REQ-012 branch_addr_i  input  32  redirect target; bit 0 ignored.
REQ-013 hwlp_jump_i  input  1  hardware-loop jump on the current instruction.
REQ-014 hwlp_target_i  input  32  hardware-loop target address.

Function
REQ-015 SHALL implement states ALIGNED, MISALIGNED, and BRANCH_MISALIGNED, plus a 16-bit held-half register r_h.
REQ-016 An instruction half SHALL be compressed iff bits [1:0] != 2'b11.
REQ-017 ALIGNED, low half 32-bit: SHALL output instr_valid_o = fetch_valid_i and instr_aligned_o = fetch_rdata_i; on handshake SHALL set fetch_ready_o = 1, pc += 4, and stay ALIGNED.
REQ-018 ALIGNED, low half compressed: SHALL output {16'b0, rdata[15:0]} with instr_valid_o = fetch_valid_i; on handshake SHALL set fetch_ready_o = 1, r_h <= rdata[31:16], pc += 2, and go to MISALIGNED.
REQ-019 MISALIGNED, r_h compressed: SHALL output {16'b0, r_h} with instr_valid_o = 1, independent of fetch_valid_i; on handshake SHALL set fetch_ready_o = 0, pc += 2, and go to ALIGNED.
REQ-020 MISALIGNED, r_h 32-bit: SHALL output {rdata[15:0], r_h} with instr_valid_o = fetch_valid_i; on handshake SHALL set fetch_ready_o = 1, r_h <= rdata[31:16], pc += 4, and stay MISALIGNED.
REQ-021 BRANCH_MISALIGNED: instr_valid_o SHALL be 0; when fetch_valid_i is high, SHALL set fetch_ready_o = 1 and r_h <= rdata[31:16], discard the low half, and go to MISALIGNED; this costs one bubble cycle.
REQ-022 fetch_ready_o SHALL be 1 only in the cycles listed in REQ-017 to REQ-021; without a handshake, state, pc and r_h SHALL hold.
REQ-023 branch_i SHALL have priority over everything: in that cycle instr_valid_o = 0 and fetch_ready_o = 0; next cycle pc = {branch_addr_i[31:1], 1'b0}; state = branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED; r_h is don't-care.
REQ-024 pc arithmetic SHALL be 32-bit and wrap modulo 2^32, e.g. 32'hFFFF_FFFE + 2 = 0.
REQ-025 instr_aligned_o and pc_o SHALL be combinational from state and current inputs; latency from fetch_valid_i to instr_valid_o is 0 cycles, except after a misaligned redirect (REQ-021).
REQ-026 instr_aligned_o SHALL remain stable while instr_valid_o = 1 and instr_ready_i = 0, given stable fetch inputs.

Reset
REQ-027 During reset: state = ALIGNED, pc = 0, r_h = 0, instr_valid_o = 0, fetch_ready_o = 0.
REQ-028 Reset asserted mid-operation SHALL discard any held half immediately; after release the first instruction SHALL be taken only after a branch_i (boot redirect).

Configuration
REQ-029 With macro CV32E40P_ALIGNER_HWLP_EN defined: a handshake with hwlp_jump_i = 1 SHALL redirect exactly as branch_i to hwlp_target_i, effective next cycle, and SHALL consume a fetch word only if REQ-017, REQ-018 or REQ-020 apply.
REQ-030 Without CV32E40P_ALIGNER_HWLP_EN: the hwlp_jump_i and hwlp_target_i ports SHALL exist but be ignored; behaviour is identical to the hwlp_jump_i = 0 case.

Structure
REQ-031 The state enum aligner_state_e (ALIGNED, MISALIGNED, BRANCH_MISALIGNED) SHALL be defined in cv32e40p_pkg.
REQ-032 The block SHALL be a single module with no sub-module; its output feeds the compressed decoder directly.

Verification
REQ-033 Branch to 0x100, word 0x0041_0113 (addi, 32-bit), ready = 1 -> instr 0x0041_0113, pc 0x100, fetch_ready_o = 1, next pc 0x104.
REQ-034 Branch to 0x200, word 0x4501_4505 (two c.li) -> instr 0x0000_4505 at pc 0x200; next cycle instr 0x0000_4501 at pc 0x202 with fetch_valid_i = 0; fetch_ready_o high only in the first cycle.
REQ-035 Branch to 0x300, words 0x0113_4505 then 0xABCD_0041 -> 0x0000_4505 at pc 0x300, then 0x0041_0113 at pc 0x302 consuming the second word, then r_h = 0xABCD held.
REQ-036 Branch to 0x402, word 0x4505_FFFF -> one bubble cycle, then 0x0000_4505 at pc 0x402, then pc 0x404 in ALIGNED.
REQ-037 instr_ready_i = 0 for 3 cycles, then a branch_i pulse mid-stall -> outputs stable during the stall, zero words consumed, next pc = branch target.
REQ-038 rst_n low for one cycle while r_h = 0x0041 in MISALIGNED -> state = ALIGNED, instr_valid_o = 0, pc = 0 asynchronously; with the macro defined, an hwlp_jump_i handshake to 0x500 -> next pc = 0x500.
